rf_multiport_bypass: RTL
========================

Name: rf_multiport_bypass

Overview:
- Parametrised successor to the team's fixed 32x16 quad-port distributed-RAM register file.
- Generalises data width, depth and number of read ports.
- Adds three behaviours: write-first bypass, optional registered read outputs, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits in the IPPro datapath as the register file / local memory; an array column maps to one distributed-RAM primitive.

Parameters:
- DATA_W, 16, data width in bits; must be even (2-bit columns).
- DEPTH, 32, number of entries; power of two, 32 or 64.
- ADDR_W, 5, address width; equals log2(DEPTH).
- NUM_RD, 3, number of independent asynchronous read ports (1..4).
- READ_LAT, 0, read latency: 0 = combinational, 1 = registered outputs.
- BYPASS, 1, 1 = a read at the address being written returns RF_DIN (write-first); 0 = returns old contents.

Ports:
- RF_CLK  in  1  clock; all state changes on rising edge.
- RF_RST  in  1  synchronous, active-high reset.
- RF_WE  in  1  write enable.
- RF_ADDRD  in  ADDR_W  write address; also the address of the RF_DOD read-back port.
- RF_DIN  in  DATA_W  write data.
- RF_RADDR  in  NUM_RD*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
- RF_DO  out  NUM_RD*DATA_W  packed read data; port k is at [k*DATA_W +: DATA_W].
- RF_DOD  out  DATA_W  contents at RF_ADDRD.
- RF_CLR  in  1  single-cycle request to zero the whole array.
- RF_BUSY  out  1  high while the clear sequencer owns the array.

Behaviour:
- Reset: RF_RST is synchronous and active-high.
  - The FSM enters CLEAR and the clear counter goes to 0.
  - RF_BUSY is 1 from the first edge after reset.
  - Output registers (READ_LAT=1) reset to 0.
  - The array itself is not reset; it is zeroed by the sequencer.
- FSM states are IDLE and CLEAR.
  - CLEAR: each cycle writes 0 to entry cnt and increments cnt. On the write of cnt=DEPTH-1 the FSM goes to IDLE and cnt wraps to 0.
  - RF_BUSY deasserts on the edge that enters IDLE. CLEAR therefore lasts exactly DEPTH cycles.
  - IDLE: RF_CLR=1 moves the FSM to CLEAR with cnt=0 on the next edge.
  - RF_CLR while already in CLEAR is ignored; it does not restart the sweep.
- Reset asserted mid-clear restarts the sweep at cnt=0.
- While RF_BUSY=1:
  - External RF_WE is dropped and never queued.
  - All read outputs (RF_DO, RF_DOD) are forced to 0, whatever partial array state exists.
- Write: when IDLE and RF_WE=1, mem[RF_ADDRD] <= RF_DIN on the rising edge.
- Read with READ_LAT=0:
  - RF_DO[k] = mem[RF_RADDR[k]] combinationally.
  - If BYPASS=1, RF_WE=1, IDLE and RF_RADDR[k]==RF_ADDRD, then RF_DO[k] = RF_DIN.
  - RF_DOD follows the same rule against RF_ADDRD.
- Read with READ_LAT=1:
  - Each output register captures the READ_LAT=0 value on the edge, giving one cycle of latency.
  - With BYPASS=1, a same-cycle write and read of one address yields the new data one cycle later. With BYPASS=0 it yields the old data.
- Any number of read ports may address the same entry simultaneously; every such port returns identical data.
- Addresses are exactly ADDR_W bits wide, so out-of-range addressing is not possible.

Decomposition:
- Shared include (parameters.v): default DATA_W, DEPTH, NUM_RD, plus localparams for the FSM state encodings ST_IDLE and ST_CLEAR.
- Sub-module rf_ram_column: one 2-bit-wide, DEPTH-entry column with NUM_RD+1 asynchronous read ports and one synchronous write port. It is instantiated DATA_W/2 times in a generate loop and maps onto distributed-RAM primitives.
- The top level holds:
  - the FSM and clear counter,
  - the write mux between the sequencer and the external port,
  - the bypass comparators,
  - the output masking and the output registers.

Test Plan:
- Reset sweep, DEPTH=32: release reset, then observe RF_BUSY.
  - RF_BUSY stays high for exactly 32 cycles, then falls.
  - Reading all 32 entries afterwards returns 0x0000.
- Basic write/read, READ_LAT=0:
  - Write 0xA5C3 to address 7 and 0x1234 to address 31.
  - Set port0=7, port1=31, port2=7 → outputs 0xA5C3, 0x1234, 0xA5C3 in the same cycle.
- Bypass:
  - Entry 4 holds 0x0001. In one cycle, write 0xBEEF to address 4 and read address 4.
  - BYPASS=1 → RF_DO[0] = 0xBEEF in that cycle. BYPASS=0 → RF_DO[0] = 0x0001.
- Registered read, READ_LAT=1:
  - Read address 7 (holding 0xA5C3) at cycle n.
  - RF_DO[0] = 0xA5C3 at n+1, and holds the previous value during cycle n.
- Clear request:
  - Fill the array with 0xFFFF, then pulse RF_CLR. Attempt to write 0x5555 to address 3 at cycle 5 of the clear.
  - RF_BUSY is high for 32 cycles, outputs read 0 while busy, and address 3 reads 0x0000 afterwards.
- Reset mid-clear:
  - Assert RF_RST at cycle 10 of a clear.
  - The sweep restarts and RF_BUSY stays high for 32 cycles from the reset edge.
  - Asserting RF_CLR during the restarted sweep does not extend it.

Source files
------------

// File: rtl/rf_multiport_bypass_pkg.sv
// rf_multiport_bypass_pkg: default geometry and clear-sequencer state encoding
package rf_multiport_bypass_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} rf_state_e;
endpackage

// File: rtl/rf_multiport_bypass_ram_column.sv
// rf_ram_column: 2-bit wide column, async multi-port read, sync single write
module rf_ram_column #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NP     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [1:0]        wdata_i,
  input  logic [NP*ADDR_W-1:0] raddr_i,
  output logic [NP*2-1:0]   rdata_o
);
  logic [1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  for (genvar p = 0; p < NP; p++) begin : g_rd
    assign rdata_o[2*p +: 2] = mem[raddr_i[p*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/rf_multiport_bypass.sv
// rf_multiport_bypass: parametrised multi-read register file with write-first
// bypass, optional registered reads and a hardware clear sequencer
module rf_multiport_bypass
  import rf_multiport_bypass_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int READ_LAT = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     RF_CLK,
  input  logic                     RF_RST,
  input  logic                     RF_WE,
  input  logic [ADDR_W-1:0]        RF_ADDRD,
  input  logic [DATA_W-1:0]        RF_DIN,
  input  logic [NUM_RD*ADDR_W-1:0] RF_RADDR,
  output logic [NUM_RD*DATA_W-1:0] RF_DO,
  output logic [DATA_W-1:0]        RF_DOD,
  input  logic                     RF_CLR,
  output logic                     RF_BUSY
);
  localparam int NP   = NUM_RD + 1;
  localparam int NCOL = DATA_W / 2;
  rf_state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic busy, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NP*ADDR_W-1:0] rd_addr;
  logic [NP*2-1:0] col_rd [NCOL];
  logic [DATA_W-1:0] raw [NP];
  logic [DATA_W-1:0] val [NP];
  logic [DATA_W-1:0] rd_q [NP];
  logic [DATA_W-1:0] rd_o [NP];
  assign busy    = state_q == ST_CLEAR;
  assign RF_BUSY = busy;
  // DEPTH is a power of two, so the counter wraps to 0 on its own after the last entry
  always_comb begin
    state_d = busy ? (&cnt_q ? ST_IDLE : ST_CLEAR) : (RF_CLR ? ST_CLEAR : ST_IDLE);
    cnt_d   = busy ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge RF_CLK)
    if (RF_RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  assign wr_en   = busy | RF_WE;
  assign wr_addr = busy ? cnt_q : RF_ADDRD;
  assign wr_data = busy ? '0 : RF_DIN;
  // the extra read port on every column serves RF_DOD
  assign rd_addr = {RF_ADDRD, RF_RADDR};
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    rf_ram_column #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NP(NP)) u_col (
      .clk     (RF_CLK),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (wr_data[2*c +: 2]),
      .raddr_i (rd_addr),
      .rdata_o (col_rd[c])
    );
  end
  always_comb begin
    raw = '{default: '0};
    val = '{default: '0};
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < NCOL; c++) raw[p][2*c +: 2] = col_rd[c][2*p +: 2];
      val[p] = busy ? '0 :
               (BYPASS != 0 && RF_WE && rd_addr[p*ADDR_W +: ADDR_W] == RF_ADDRD) ? RF_DIN : raw[p];
    end
  end
  always_ff @(posedge RF_CLK)
    if (RF_RST) rd_q <= '{default: '0};
    else rd_q <= val;
  // masking after the register keeps outputs at zero on the first busy cycle too
  for (genvar p = 0; p < NP; p++) begin : g_out
    assign rd_o[p] = busy ? '0 : (READ_LAT != 0 ? rd_q[p] : val[p]);
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_do
    assign RF_DO[k*DATA_W +: DATA_W] = rd_o[k];
  end
  assign RF_DOD = rd_o[NUM_RD];
endmodule
